// File: rtl/requant_argmax.sv
// requant_argmax: requantizes 64-bit dot-product results to int32 (round-half-up
// shift, saturation, optional ReLU), buffers one layer's activations and tracks
// the running argmax/max across the pass.
module requant_argmax #(
  parameter int N_NEURONS = 10,
  parameter int IDX_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [5:0]        shift_i,
  input  logic              relu_en_i,
  input  logic              in_valid_i,
  input  logic [63:0]       in_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              act_valid_o,
  output logic [31:0]       act_o,
  output logic [IDX_W-1:0]  act_idx_o,
  output logic [IDX_W-1:0]  argmax_o,
  output logic [31:0]       max_o,
  output logic              sat_o,
  input  logic [IDX_W-1:0]  rd_addr_i,
  output logic [31:0]       rd_data_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  // one extra bit so the count can reach N_NEURONS even when N == 2^IDX_W
  localparam int CNT_W = IDX_W + 1;
  localparam logic signed [64:0] SAT_MAX = 65'sh0_7FFF_FFFF;
  localparam logic signed [64:0] SAT_MIN = -65'sh0_8000_0000;

  state_t             state_q, state_d;
  logic               start_d_q, valid_d_q;
  logic [5:0]         shift_q, shift_d;
  logic               relu_q, relu_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               s1_vld_q, s1_vld_d;
  logic signed [64:0] s1_t_q, s1_t_d;
  logic               act_valid_q, act_valid_d;
  logic [31:0]        act_q, act_d;
  logic [IDX_W-1:0]   act_idx_q, act_idx_d;
  logic [IDX_W-1:0]   argmax_q, argmax_d;
  logic [31:0]        max_q, max_d;
  logic               sat_q, sat_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic               start_pulse, in_pulse, fire, wr_en, sat_hit;
  logic signed [64:0] ext, rnd, sum;
  logic [31:0]        act_new;

  logic [31:0] mem [N_NEURONS];

  // edge detection; a result rising together with a start edge is dropped
  always_comb begin
    start_pulse = start_i & ~start_d_q;
    in_pulse    = in_valid_i & ~valid_d_q & ~start_pulse & (state_q == COLLECT);
  end

  // stage 1: round-half-up arithmetic shift at 65 bits so the add never wraps
  always_comb begin
    ext    = {in_data_i[63], in_data_i};
    rnd    = (shift_q == 6'd0) ? 65'sd0 : (65'sd1 <<< (shift_q - 6'd1));
    sum    = ext + rnd;
    s1_t_d = sum >>> shift_q;
  end

  // stage 2: saturate to int32, then ReLU (so a clamped negative still flags sat)
  always_comb begin
    sat_hit = 1'b0;
    act_new = s1_t_q[31:0];
    if (s1_t_q > SAT_MAX) begin
      act_new = 32'h7FFF_FFFF;
      sat_hit = 1'b1;
    end else if (s1_t_q < SAT_MIN) begin
      act_new = 32'h8000_0000;
      sat_hit = 1'b1;
    end
    if (relu_q && act_new[31]) act_new = 32'd0;
  end

  // control: FSM, pass configuration, buffer write and argmax tracking
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    count_d     = count_q;
    s1_vld_d    = in_pulse;
    act_valid_d = 1'b0;
    act_d       = act_q;
    act_idx_d   = act_idx_q;
    argmax_d    = argmax_q;
    max_d       = max_q;
    sat_d       = sat_q;
    wr_en       = 1'b0;
    fire        = s1_vld_q & ~start_pulse & (state_q == COLLECT);
    if (start_pulse) begin
      state_d  = COLLECT;
      shift_d  = (shift_i > 6'd62) ? 6'd62 : shift_i;
      relu_d   = relu_en_i;
      count_d  = '0;
      sat_d    = 1'b0;
      s1_vld_d = 1'b0;
    end else if (fire) begin
      wr_en       = 1'b1;
      act_valid_d = 1'b1;
      act_d       = act_new;
      act_idx_d   = count_q[IDX_W-1:0];
      sat_d       = sat_q | sat_hit;
      // strict compare keeps the lowest index on ties
      if (count_q == '0 || $signed(act_new) > $signed(max_q)) begin
        max_d    = act_new;
        argmax_d = count_q[IDX_W-1:0];
      end
      count_d = count_q + 1'b1;
      if (count_q == CNT_W'(N_NEURONS - 1)) state_d = DONE;
    end
  end

  // registered read port; out-of-range addresses read as zero
  always_comb begin
    rd_data_d = '0;
    if (int'(rd_addr_i) < N_NEURONS) rd_data_d = mem[rd_addr_i];
  end

  // state and pipeline registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      start_d_q   <= 1'b0;
      valid_d_q   <= 1'b0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      count_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_t_q      <= '0;
      act_valid_q <= 1'b0;
      act_q       <= '0;
      act_idx_q   <= '0;
      argmax_q    <= '0;
      max_q       <= '0;
      sat_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      start_d_q   <= start_i;
      valid_d_q   <= in_valid_i;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      count_q     <= count_d;
      s1_vld_q    <= s1_vld_d;
      s1_t_q      <= s1_t_d;
      act_valid_q <= act_valid_d;
      act_q       <= act_d;
      act_idx_q   <= act_idx_d;
      argmax_q    <= argmax_d;
      max_q       <= max_d;
      sat_q       <= sat_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // activation buffer storage, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) mem[count_q[IDX_W-1:0]] <= act_new;
  end

  assign busy_o      = (state_q == COLLECT);
  assign done_o      = (state_q == DONE);
  assign act_valid_o = act_valid_q;
  assign act_o       = act_q;
  assign act_idx_o   = act_idx_q;
  assign argmax_o    = argmax_q;
  assign max_o       = max_q;
  assign sat_o       = sat_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: doc/requant_argmax.md
# requant_argmax

Output stage of the neuron layer, directly downstream of the dot-product unit. Each new dot-product result (64-bit signed, bias already added) is detected by a rising edge of its result-valid. The stage requantizes the result to int32 (arithmetic right shift with round-half-up, then saturation), applies an optional ReLU and stores it in an N-entry activation buffer. It tracks the running argmax/max across the layer and signals layer completion after N_NEURONS results; the CPU reads back the buffer and the class index.

## Interface
- N_NEURONS, 10, results per layer pass (1..16)
- IDX_W, 4, index width; must satisfy 2^IDX_W >= N_NEURONS
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  level; rising edge begins a new layer pass
- shift_i  in  6  right-shift amount; sampled on start edge
- relu_en_i  in  1  ReLU enable; sampled on start edge
- in_valid_i  in  1  upstream result-valid (level); rising edge = one new result
- in_data_i  in  64  signed result; sampled on the in_valid_i rising edge
- busy_o  out  1  high while collecting results
- done_o  out  1  high from pass completion until the next start edge
- act_valid_o  out  1  one-cycle pulse per stored activation
- act_o  out  32  activation written with act_valid_o
- act_idx_o  out  IDX_W  buffer index of act_o
- argmax_o  out  IDX_W  index of the maximum activation of the pass
- max_o  out  32  maximum activation value of the pass
- sat_o  out  1  sticky; set if any result of the pass saturated
- rd_addr_i  in  IDX_W  buffer read address
- rd_data_o  out  32  buffer read data, registered

## Operation
- Edge detectors:
  - start_d and valid_d are registered copies of the inputs.
  - start_pulse = start_i & ~start_d; in_pulse = in_valid_i & ~valid_d.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE/DONE, start_pulse -> COLLECT. Latch shift_i and relu_en_i; clear count, sat_o and done_o; flush the pipeline.
  - COLLECT, start_pulse -> restart as above. In-flight results are dropped.
  - COLLECT, N_NEURONS-th activation written -> DONE.
  - in_pulse outside COLLECT is ignored. in_pulse in the same cycle as start_pulse is ignored.
- Arithmetic, stage 1:
  - Shift amounts above 62 are clamped to 62.
  - rnd = 0 if shift = 0, else 2^(shift-1).
  - t = (in_data + rnd) >>> shift, computed at 65 bits (no wrap).
- Arithmetic, stage 2:
  - Clamp t to [-2^31, 2^31-1]; any clamp sets sat_o.
  - If relu_en, negative values become 0. ReLU is applied after saturation.
- Buffer write: the activation goes to buffer[count], then count increments. count does not wrap; extra pulses after N_NEURONS are ignored because the state has left COLLECT.
- Argmax:
  - The first activation of a pass loads max/argmax unconditionally.
  - Later activations replace the current maximum only if strictly greater (signed compare), so ties keep the lowest index.
- Read port: rd_data_o <= buffer[rd_addr_i] every cycle. Addresses >= N_NEURONS return 0.
- Buffer storage is not reset; its contents are undefined until written.

## Timing
- Reset values: busy_o, done_o, act_valid_o, sat_o = 0; act_o, act_idx_o, argmax_o, max_o, rd_data_o = 0; state IDLE; start_d, valid_d, count = 0.
- The reset takes effect at the clock edge and overrides everything, including mid-pass.
- busy_o goes high the cycle after the start edge.
- Latency: with in_pulse sampled at edge k, stage 1 registers at k and stage 2 at k+1. act_valid_o/act_o/act_idx_o are valid in the cycle after edge k+1, and the buffer write and argmax update occur at edge k+1.
- On the final activation, done_o rises and busy_o falls in the same cycle as its act_valid_o. argmax_o and max_o are final in that cycle.
- Throughput: one result per 2 cycles minimum, because each result needs an in_valid_i rising edge. Back-to-back results are fully pipelined.
- rd_data_o appears 1 cycle after rd_addr_i.
- done_o, argmax_o, max_o and sat_o hold until the next start edge.

## Test plan
- Basic pass, shift 0, ReLU off, 10 pulses with data 5,-3,7,7,0,1,2,-9,4,6 -> act_o equals the inputs, argmax_o=2, max_o=7, done_o=1, busy_o=0, sat_o=0; rd_addr 7 -> rd_data -9 one cycle later.
- Rounding, shift 16, data 98304 -> 2; data -98304 -> -1; data 32767 -> 0.
- Saturation, shift 0, data 2^40 -> 0x7FFFFFFF and sat_o=1; data -2^40 -> 0x80000000.
- ReLU on, all ten inputs negative -> all activations 0, argmax_o=0, max_o=0.
- Edge semantics:
  - Holding in_valid_i high for 5 cycles counts one result.
  - A pulse in IDLE is ignored.
  - A start edge coinciding with an in_valid rise drops that result and leaves count=0.
- Mid-pass events:
  - rst_i after 4 results -> all outputs 0, state IDLE.
  - A new start after 4 results -> restart; the next 10 results complete the pass.
